// File: rtl/observer_program_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// observer_program_memory_arbiter_if
// Bus bundle around the Mk8 Observer program-memory arbiter.
//   ins_* : CPU instruction-fetch Avalon-MM master (read only)
//   ldr_* : host loader Avalon-MM master (read/write, byte enables)
//   mem_* : single-port program memory (registered address, 1-cycle read)
// Modports:
//   slave  : the arbiter (slave to both masters, drives the memory port)
//   master : the environment (CPU, loader and the memory itself)
// ---------------------------------------------------------------------------
interface observer_program_memory_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] ins_address;
  logic              ins_read;
  logic              ins_waitrequest;
  logic [DATA_W-1:0] ins_readdata;
  logic              ins_readdatavalid;

  logic [ADDR_W-1:0] ldr_address;
  logic              ldr_read;
  logic              ldr_write;
  logic [BE_W-1:0]   ldr_byteenable;
  logic [DATA_W-1:0] ldr_writedata;
  logic              ldr_waitrequest;
  logic [DATA_W-1:0] ldr_readdata;
  logic              ldr_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  ins_address, ins_read,
    output ins_waitrequest, ins_readdata, ins_readdatavalid,
    input  ldr_address, ldr_read, ldr_write, ldr_byteenable, ldr_writedata,
    output ldr_waitrequest, ldr_readdata, ldr_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output ins_address, ins_read,
    input  ins_waitrequest, ins_readdata, ins_readdatavalid,
    output ldr_address, ldr_read, ldr_write, ldr_byteenable, ldr_writedata,
    input  ldr_waitrequest, ldr_readdata, ldr_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/observer_program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// observer_program_memory_arbiter
// Boot sequencer + two-master arbiter for the Mk8 Observer 4096x32
// single-port program memory.
//   BOOT : CPU fetches are held off; the loader owns the memory.
//   RUN  : one grant per cycle, decided combinationally from live requests.
// Ports:
//   clk, reset (async, active high)
//   boot_done  : loader pulse, BOOT -> RUN
//   cpu_run    : high in RUN, releases the CPU
//   bus        : ins_*/ldr_*/mem_* bundle (slave modport)
// Option macro PMEM_ARB_ROUND_ROBIN_EN: on contention the master not granted
// last wins; without it the loader always wins (fetch may starve).
// ---------------------------------------------------------------------------
module observer_program_memory_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic boot_done,
  output logic cpu_run,
  observer_program_memory_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t state;
  logic   ldr_req, ins_req, ldr_first;
  logic   grant_ldr, grant_ins, grant_ldr_wr;
  logic   rd_vld, rd_ldr;   // read in flight and its owner (1 = loader)

  // A simultaneous read+write from the loader is a write.
  assign ldr_req = bus.ldr_read | bus.ldr_write;
  assign ins_req = bus.ins_read & (state == RUN);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic last_ldr;   // 0 = fetch granted last (reset value)
  assign ldr_first = ~last_ldr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       last_ldr <= 1'b0;
    else if (grant_ldr || grant_ins) last_ldr <= grant_ldr;
  end
`else
  assign ldr_first = 1'b1;
`endif

  // ldr_first only matters when both request, which cannot happen in BOOT.
  assign grant_ldr    = ~reset & ldr_req & (~ins_req | ldr_first);
  assign grant_ins    = ~reset & ins_req & ~grant_ldr;
  assign grant_ldr_wr = grant_ldr & bus.ldr_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      cpu_run <= 1'b0;
    end else if (state == BOOT && boot_done) begin
      state   <= RUN;
      cpu_run <= 1'b1;
    end
  end

  // Memory data lags the grant by one cycle; remember who asked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld <= 1'b0;
      rd_ldr <= 1'b0;
    end else begin
      rd_vld <= grant_ins | (grant_ldr & ~bus.ldr_write);
      rd_ldr <= grant_ldr;
    end
  end

  assign bus.mem_address    = grant_ldr ? bus.ldr_address : bus.ins_address;
  assign bus.mem_byteenable = grant_ldr_wr ? bus.ldr_byteenable : {BE_W{1'b1}};
  assign bus.mem_chipselect = grant_ldr | grant_ins;
  assign bus.mem_write      = grant_ldr_wr;
  assign bus.mem_writedata  = bus.ldr_writedata;
  assign bus.mem_clken      = ~reset;

  assign bus.ins_waitrequest   = reset | (bus.ins_read & ~grant_ins);
  assign bus.ldr_waitrequest   = reset | (ldr_req & ~grant_ldr);
  assign bus.ins_readdata      = bus.mem_readdata;
  assign bus.ldr_readdata      = bus.mem_readdata;
  assign bus.ins_readdatavalid = ~reset & rd_vld & ~rd_ldr;
  assign bus.ldr_readdatavalid = ~reset & rd_vld & rd_ldr;

endmodule

// File: tb/tb_observer_program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_observer_program_memory_arbiter
// Directed scenarios plus randomized traffic checked against a reference
// memory image and the arbitration rules. Includes a behavioural program
// memory (registered address, unregistered data).
// ---------------------------------------------------------------------------
module tb_observer_program_memory_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic boot_done = 1'b0;
  logic cpu_run;

  observer_program_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  observer_program_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .boot_done (boot_done),
    .cpu_run   (cpu_run),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return {a, 4'hA, ~a[7:0], 8'h5C};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // ---- program memory model -------------------------------------------
  logic [31:0] mem_arr [0:4095];
  bit          mem_wr  [0:4095];
  logic [11:0] mem_aq = '0;
  logic [31:0] mem_cur;

  assign mem_cur = mem_wr[bus.mem_address] ? mem_arr[bus.mem_address] : init_val(bus.mem_address);

  always @(posedge clk) begin
    if (bus.mem_clken) begin
      if (bus.mem_chipselect && bus.mem_write) begin
        mem_arr[bus.mem_address] <= merge(mem_cur, bus.mem_writedata, bus.mem_byteenable);
        mem_wr[bus.mem_address]  <= 1'b1;
      end
      mem_aq <= bus.mem_address;
    end
  end
  assign bus.mem_readdata = mem_wr[mem_aq] ? mem_arr[mem_aq] : init_val(mem_aq);

  // ---- reference state ------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [0:4095];
  bit          run_m    = 1'b0;
  bit          last_ldr = 1'b0;

  task automatic drive(input bit ir, input logic [11:0] ia, input bit lr, input bit lw,
                       input logic [11:0] la, input logic [3:0] be, input logic [31:0] wd);
    bus.ins_read       = ir;
    bus.ins_address    = ia;
    bus.ldr_read       = lr;
    bus.ldr_write      = lw;
    bus.ldr_address    = la;
    bus.ldr_byteenable = be;
    bus.ldr_writedata  = wd;
  endtask

  function automatic logic [11:0] pick_addr();
    int p;
    p = $urandom_range(0, 7);
    if (p == 0) return 12'h000;
    if (p == 1) return 12'hFFF;
    return 12'($urandom);
  endfunction

  // All tasks start and end just after a rising edge.
  task automatic test_reset();
    reset = 1'b1;
    drive(1, 12'h000, 1, 0, 12'h000, 4'hF, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({cpu_run, bus.ins_readdatavalid, bus.ldr_readdatavalid, bus.mem_chipselect,
         bus.mem_write, bus.mem_clken} !== 6'b0)
      begin n_fail++; $display("FAIL reset_outputs: got %b required 000000",
        {cpu_run, bus.ins_readdatavalid, bus.ldr_readdatavalid, bus.mem_chipselect,
         bus.mem_write, bus.mem_clken}); end
    n_checks++;
    if ({bus.ins_waitrequest, bus.ldr_waitrequest} !== 2'b11)
      begin n_fail++; $display("FAIL reset_waitrequest: got %b required 11",
        {bus.ins_waitrequest, bus.ldr_waitrequest}); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    run_m = 1'b0; last_ldr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_clken !== 1'b1)
      begin n_fail++; $display("FAIL clken_after_reset: got %b required 1", bus.mem_clken); end
    @(posedge clk); #1;
  endtask

  task automatic test_boot_fetch();
    for (int c = 0; c < 5; c++) begin
      drive(1, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.ins_waitrequest, bus.mem_chipselect, cpu_run, bus.ins_readdatavalid} !== 4'b1000)
        begin n_fail++; $display("FAIL boot_fetch_held c%0d: got %b required 1000", c,
          {bus.ins_waitrequest, bus.mem_chipselect, cpu_run, bus.ins_readdatavalid}); end
      @(posedge clk); #1;
    end
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
  endtask

  // Write then read back through the loader; checks the read data value.
  task automatic loader_wr_rd(input string nm, input logic [11:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] want);
    drive(0, 12'h000, 0, 1, a, be, wd);
    @(negedge clk);
    n_checks++;
    if ({bus.ldr_waitrequest, bus.mem_chipselect, bus.mem_write} !== 3'b011)
      begin n_fail++; $display("FAIL %s_write_grant: got %b required 011", nm,
        {bus.ldr_waitrequest, bus.mem_chipselect, bus.mem_write}); end
    ref_mem[a] = merge(ref_mem[a], wd, be);
    @(posedge clk); #1;
    drive(0, 12'h000, 1, 0, a, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.ldr_waitrequest, bus.ldr_readdatavalid} !== 2'b00)
      begin n_fail++; $display("FAIL %s_read_grant: got %b required 00", nm,
        {bus.ldr_waitrequest, bus.ldr_readdatavalid}); end
    @(posedge clk); #1;
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.ldr_readdatavalid, bus.ins_readdatavalid} !== 2'b10 || bus.ldr_readdata !== want)
      begin n_fail++; $display("FAIL %s_readback: got v=%b%b d=%h required v=10 d=%h", nm,
        bus.ldr_readdatavalid, bus.ins_readdatavalid, bus.ldr_readdata, want); end
    @(posedge clk); #1;
    last_ldr = 1'b1;
  endtask

  task automatic test_loader_rw();
    loader_wr_rd("ldr_rw", 12'h010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF);
  endtask

  task automatic test_partial_write();
    loader_wr_rd("partial", 12'h010, 4'h2, 32'h0000AA00, 32'hDEADAAEF);
  endtask

  task automatic test_boot_release();
    boot_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_run !== 1'b0)
      begin n_fail++; $display("FAIL boot_pulse_cycle: cpu_run got %b required 0", cpu_run); end
    @(posedge clk); #1;
    boot_done = 1'b0;
    run_m = 1'b1;
    drive(1, 12'h010, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({cpu_run, bus.ins_waitrequest, bus.mem_chipselect} !== 3'b101)
      begin n_fail++; $display("FAIL first_fetch: got %b required 101",
        {cpu_run, bus.ins_waitrequest, bus.mem_chipselect}); end
    @(posedge clk); #1;
    drive(1, 12'h011, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (bus.ins_readdatavalid !== 1'b1 || bus.ins_readdata !== ref_mem[12'h010])
      begin n_fail++; $display("FAIL fetch0_data: got v=%b d=%h required v=1 d=%h",
        bus.ins_readdatavalid, bus.ins_readdata, ref_mem[12'h010]); end
    @(posedge clk); #1;
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (bus.ins_readdatavalid !== 1'b1 || bus.ins_readdata !== ref_mem[12'h011])
      begin n_fail++; $display("FAIL fetch1_data: got v=%b d=%h required v=1 d=%h",
        bus.ins_readdatavalid, bus.ins_readdata, ref_mem[12'h011]); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.ins_readdatavalid !== 1'b0)
      begin n_fail++; $display("FAIL fetch_drain: got %b required 0", bus.ins_readdatavalid); end
    @(posedge clk); #1;
    last_ldr = 1'b0;
  endtask

  // Both masters read for 4 cycles: RR gives L,I,L,I; fixed gives L,L,L,L.
  task automatic test_contention();
    bit el, pl, pi;
    logic [31:0] pd;
    pl = 0; pi = 0; pd = '0;
    for (int k = 0; k < 5; k++) begin
      el = RR ? (k % 2 == 0) : 1'b1;
      if (k < 4) drive(1, 12'h100 + 12'(k), 1, 0, 12'h020 + 12'(k), 4'h0, 32'h0);
      else       drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if ({bus.ldr_waitrequest, bus.ins_waitrequest} !== {~el, el})
          begin n_fail++; $display("FAIL contention_grant k%0d: got ldr/ins wait %b%b required %b%b",
            k, bus.ldr_waitrequest, bus.ins_waitrequest, ~el, el); end
      end
      n_checks++;
      if ({bus.ldr_readdatavalid, bus.ins_readdatavalid} !== {pl, pi} ||
          ((pl | pi) && (bus.ldr_readdata !== pd || bus.ins_readdata !== pd)))
        begin n_fail++; $display("FAIL contention_data k%0d: got v=%b%b d=%h required v=%b%b d=%h",
          k, bus.ldr_readdatavalid, bus.ins_readdatavalid, bus.ldr_readdata, pl, pi, pd); end
      pl = (k < 4) && el;
      pi = (k < 4) && !el;
      pd = el ? ref_mem[12'h020 + 12'(k)] : ref_mem[12'h100 + 12'(k)];
      @(posedge clk); #1;
    end
    last_ldr = RR ? 1'b0 : 1'b1;
  endtask

  // Random traffic; expectations follow the arbitration rules on a memory image.
  task automatic test_random(input string nm, input int n);
    bit ir, lr, lw, lreq, ireq, wl, wi, pl, pi;
    logic [11:0] ia, la;
    logic [3:0]  be;
    logic [31:0] wd, pd;
    pl = 0; pi = 0; pd = '0;
    for (int c = 0; c <= n; c++) begin
      ir = (c < n) && ($urandom_range(0, 1) == 1);
      lr = (c < n) && ($urandom_range(0, 2) == 0);
      lw = (c < n) && ($urandom_range(0, 2) == 0);
      ia = pick_addr(); la = pick_addr();
      be = 4'($urandom); wd = $urandom;
      drive(ir, ia, lr, lw, la, be, wd);
      boot_done = run_m && (c < n) && ($urandom_range(0, 3) == 0);
      lreq = lr | lw;
      ireq = ir & run_m;
      wl = lreq && !(ireq && RR && last_ldr);
      wi = ireq && !wl;
      @(negedge clk);
      n_checks++;
      if ({bus.ins_waitrequest, bus.ldr_waitrequest, bus.mem_chipselect, bus.mem_write, cpu_run}
          !== {ir & ~wi, lreq & ~wl, wl | wi, wl & lw, run_m})
        begin n_fail++; $display("FAIL %s_ctrl c%0d: got %b required %b", nm, c,
          {bus.ins_waitrequest, bus.ldr_waitrequest, bus.mem_chipselect, bus.mem_write, cpu_run},
          {ir & ~wi, lreq & ~wl, wl | wi, wl & lw, run_m}); end
      n_checks++;
      if ({bus.ldr_readdatavalid, bus.ins_readdatavalid} !== {pl, pi} ||
          ((pl | pi) && (bus.ldr_readdata !== pd || bus.ins_readdata !== pd)))
        begin n_fail++; $display("FAIL %s_read c%0d: got v=%b%b d=%h required v=%b%b d=%h", nm, c,
          bus.ldr_readdatavalid, bus.ins_readdatavalid, bus.ldr_readdata, pl, pi, pd); end
      if (wl | wi) last_ldr = wl;
      pl = wl & lr & ~lw;
      pi = wi;
      pd = wl ? ref_mem[la] : ref_mem[ia];
      if (wl & lw) ref_mem[la] = merge(ref_mem[la], wd, be);
      @(posedge clk); #1;
      boot_done = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    drive(0, 12'h000, 1, 0, 12'h010, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.ldr_waitrequest, bus.mem_chipselect} !== 2'b01)
      begin n_fail++; $display("FAIL midread_grant: got %b required 01",
        {bus.ldr_waitrequest, bus.mem_chipselect}); end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (bus.ldr_readdatavalid !== 1'b0)
      begin n_fail++; $display("FAIL midread_in_reset: got %b required 0", bus.ldr_readdatavalid); end
    @(posedge clk); #1;
    reset = 1'b0;
    run_m = 1'b0; last_ldr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.ldr_readdatavalid, bus.ins_readdatavalid, cpu_run} !== 3'b000)
        begin n_fail++; $display("FAIL midread_after c%0d: got %b required 000", c,
          {bus.ldr_readdatavalid, bus.ins_readdatavalid, cpu_run}); end
      @(posedge clk); #1;
    end
    drive(1, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.ins_waitrequest, bus.mem_chipselect} !== 2'b10)
      begin n_fail++; $display("FAIL midread_back_in_boot: got %b required 10",
        {bus.ins_waitrequest, bus.mem_chipselect}); end
    @(posedge clk); #1;
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    drive(0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_boot_fetch();
    test_loader_rw();
    test_partial_write();
    test_random("rand_boot", 80);
    test_boot_release();
    test_contention();
    test_random("rand_run", 400);
    test_reset_mid_read();
    test_random("rand_boot2", 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
